mem_port_arbiter: RTL and testbench

- Shares one word-wide physical memory port between the pipeline's instruction-fetch requester (read-only) and data-memory requester (read/write with byte enables).
- Sits between the datapath's instr_*/data_* memory interface and the single downstream memory.
- Serialises requests, holds the granted request stable downstream, and routes the response back to the owner.
- Also counts contention cycles for performance debug.

---
 rtl/mem_port_arbiter_pkg.sv | 5 +
 rtl/mem_port_arbiter_req_latch.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 84 ++++++++
 tb/tb_mem_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state and operation types for the memory port arbiter
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, INSTR, DATA} arb_state_t;
    typedef enum logic {OP_READ, OP_WRITE} arb_op_t;
endpackage

// File: rtl/mem_port_arbiter_req_latch.sv
// mem_port_arbiter_req_latch: captures the granted request so the downstream port stays stable
module mem_port_arbiter_req_latch
    import mem_port_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MBE_W = WIDTH / 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [MBE_W-1:0] mbe_i,
    input  arb_op_t          op_i,
    output logic [WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0] wdata_o,
    output logic [MBE_W-1:0] mbe_o,
    output arb_op_t          op_o
);
    logic [WIDTH-1:0] addr_q, wdata_q;
    logic [MBE_W-1:0] mbe_q;
    arb_op_t          op_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            wdata_q <= '0;
            mbe_q   <= '0;
            op_q    <= OP_READ;
        end else if (load_i) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            mbe_q   <= mbe_i;
            op_q    <= op_i;
        end
    end
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign mbe_o   = mbe_q;
    assign op_o    = op_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters, counting contention.
// Define ARB_ROUND_ROBIN_EN to resolve contention round-robin instead of data-first.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int CNT_W = 16,
    localparam int MBE_W = WIDTH / 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             instr_read_i,
    input  logic [WIDTH-1:0] instr_addr_i,
    output logic [WIDTH-1:0] instr_rdata_o,
    output logic             instr_resp_o,
    input  logic             data_read_i,
    input  logic             data_write_i,
    input  logic [MBE_W-1:0] data_mbe_i,
    input  logic [WIDTH-1:0] data_addr_i,
    input  logic [WIDTH-1:0] data_wdata_i,
    output logic [WIDTH-1:0] data_rdata_o,
    output logic             data_resp_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic [MBE_W-1:0] mem_mbe_o,
    output logic [WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    input  logic [WIDTH-1:0] mem_rdata_i,
    input  logic             mem_resp_i,
    output logic [CNT_W-1:0] conflict_cnt_o
);
    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    arb_op_t          op_q;
    logic             ireq, dreq, pick_data, grant, contended;
    assign ireq      = instr_read_i;
    assign dreq      = data_read_i | data_write_i;
    assign grant     = state_q == IDLE && (ireq || dreq);
    assign contended = grant && ireq && dreq;
`ifdef ARB_ROUND_ROBIN_EN
    logic last_q;  // 1 when the data side won the most recent grant
    assign pick_data = dreq && (!ireq || !last_q);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) last_q <= 1'b0;
        else if (grant) last_q <= pick_data;
    end
`else
    assign pick_data = dreq;
`endif
    always_comb begin
        state_d = grant ? (pick_data ? DATA : INSTR) : (state_q != IDLE && mem_resp_i) ? IDLE : state_q;
        cnt_d   = (contended && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    mem_port_arbiter_req_latch #(.WIDTH(WIDTH), .MBE_W(MBE_W)) u_latch (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (grant),
        .addr_i (pick_data ? data_addr_i : instr_addr_i),
        .wdata_i(pick_data ? data_wdata_i : '0),
        .mbe_i  (pick_data ? data_mbe_i : '0),
        .op_i   ((pick_data && data_write_i) ? OP_WRITE : OP_READ),
        .addr_o (mem_addr_o),
        .wdata_o(mem_wdata_o),
        .mbe_o  (mem_mbe_o),
        .op_o   (op_q)
    );
    assign mem_read_o     = state_q != IDLE && op_q == OP_READ;
    assign mem_write_o    = state_q != IDLE && op_q == OP_WRITE;
    assign instr_resp_o   = state_q == INSTR && mem_resp_i;
    assign data_resp_o    = state_q == DATA && mem_resp_i;
    assign instr_rdata_o  = state_q == INSTR ? mem_rdata_i : '0;
    assign data_rdata_o   = state_q == DATA ? mem_rdata_i : '0;
    assign conflict_cnt_o = cnt_q;
    always @(posedge clk_i) if (rst_ni) assert (!(data_read_i && data_write_i));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a variable-latency memory model
module tb_mem_port_arbiter;
    localparam int CW = 8;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mbe;
        logic        wr;
        logic [31:0] rdata;
    } exp_t;
    logic          clk_i = 0, rst_ni = 0;
    logic          instr_read_i = 0, data_read_i = 0, data_write_i = 0;
    logic [31:0]   instr_addr_i = 0, data_addr_i = 0, data_wdata_i = 0;
    logic [3:0]    data_mbe_i = 0;
    logic [31:0]   instr_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic          instr_resp_o, data_resp_o, mem_read_o, mem_write_o, mem_resp_i;
    logic [3:0]    mem_mbe_o;
    logic [CW-1:0] conflict_cnt_o;
    logic [7:0]    mem_lat = 0, wcnt = 0;
    logic          stray = 0;
    exp_t          iq[$], dq[$];
    exp_t          e;
    int            tests = 0, fails = 0, n_ir = 0, n_dr = 0, cyc = 0, last_ir = 0, last_dr = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.WIDTH(32), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_read_i(instr_read_i), .instr_addr_i(instr_addr_i),
        .instr_rdata_o(instr_rdata_o), .instr_resp_o(instr_resp_o),
        .data_read_i(data_read_i), .data_write_i(data_write_i), .data_mbe_i(data_mbe_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_rdata_o(data_rdata_o), .data_resp_o(data_resp_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_mbe_o(mem_mbe_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_resp_i(mem_resp_i),
        .conflict_cnt_o(conflict_cnt_o)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a == 32'h60 ? 32'h13 : {a[15:0], ~a[15:0]};
    endfunction

    // memory answers mem_lat cycles after the strobe first appears
    assign mem_resp_i  = ((mem_read_o || mem_write_o) && wcnt >= mem_lat) || stray;
    assign mem_rdata_i = pat(mem_addr_o);
    always @(posedge clk_i) begin
        cyc++;
        wcnt <= ((mem_read_o || mem_write_o) && !mem_resp_i) ? wcnt + 8'd1 : 8'd0;
    end

    always @(negedge clk_i) if (rst_ni) begin
        if (instr_resp_o && data_resp_o) begin
            tests++; fails++;
            $display("FAIL both_resp instr_resp=1 data_resp=1 required at most one");
        end
        if (instr_resp_o) begin
            tests++; n_ir++; last_ir = cyc;
            if (iq.size() == 0) begin
                fails++;
                $display("FAIL instr_unexpected_resp addr=%h with no pending fetch", mem_addr_o);
            end else begin
                e = iq.pop_front();
                if ({mem_read_o, mem_write_o, mem_mbe_o, mem_addr_o, instr_rdata_o} !== {1'b1, 1'b0, 4'h0, e.addr, e.rdata}) begin
                    fails++;
                    $display("FAIL instr_resp got rd=%b wr=%b mbe=%h addr=%h rdata=%h required rd=1 wr=0 mbe=0 addr=%h rdata=%h",
                             mem_read_o, mem_write_o, mem_mbe_o, mem_addr_o, instr_rdata_o, e.addr, e.rdata);
                end
            end
        end
        if (data_resp_o) begin
            tests++; n_dr++; last_dr = cyc;
            if (dq.size() == 0) begin
                fails++;
                $display("FAIL data_unexpected_resp addr=%h with no pending access", mem_addr_o);
            end else begin
                e = dq.pop_front();
                if (e.wr && {mem_write_o, mem_read_o, mem_addr_o, mem_wdata_o, mem_mbe_o} !== {1'b1, 1'b0, e.addr, e.wdata, e.mbe}) begin
                    fails++;
                    $display("FAIL data_store_resp got wr=%b rd=%b addr=%h wdata=%h mbe=%h required wr=1 rd=0 addr=%h wdata=%h mbe=%h",
                             mem_write_o, mem_read_o, mem_addr_o, mem_wdata_o, mem_mbe_o, e.addr, e.wdata, e.mbe);
                end
                if (!e.wr && {mem_read_o, mem_write_o, mem_addr_o, data_rdata_o} !== {1'b1, 1'b0, e.addr, e.rdata}) begin
                    fails++;
                    $display("FAIL data_load_resp got rd=%b wr=%b addr=%h rdata=%h required rd=1 wr=0 addr=%h rdata=%h",
                             mem_read_o, mem_write_o, mem_addr_o, data_rdata_o, e.addr, e.rdata);
                end
            end
        end
    end

    task automatic instr_req(input logic [31:0] a);
        iq.push_back('{addr: a, wdata: 32'h0, mbe: 4'h0, wr: 1'b0, rdata: pat(a)});
        instr_read_i = 1; instr_addr_i = a;
        for (int c = 0; ; c++) begin
            @(negedge clk_i);
            if (instr_resp_o) break;
            if (c == 300) begin
                tests++; fails++;
                $display("FAIL instr_timeout addr=%h no instr_resp within 300 cycles", a);
                break;
            end
        end
        @(posedge clk_i); #1 instr_read_i = 0;
    endtask

    task automatic data_req(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        dq.push_back('{addr: a, wdata: wd, mbe: be, wr: wr, rdata: pat(a)});
        data_read_i = !wr; data_write_i = wr; data_addr_i = a; data_wdata_i = wd; data_mbe_i = be;
        for (int c = 0; ; c++) begin
            @(negedge clk_i);
            if (data_resp_o) break;
            if (c == 300) begin
                tests++; fails++;
                $display("FAIL data_timeout addr=%h no data_resp within 300 cycles", a);
                break;
            end
        end
        @(posedge clk_i); #1 data_read_i = 0; data_write_i = 0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            tests++;
            if ({mem_read_o, mem_write_o, mem_mbe_o, mem_addr_o, mem_wdata_o, instr_resp_o, data_resp_o,
                 instr_rdata_o, data_rdata_o, conflict_cnt_o} !== '0) begin
                fails++;
                $display("FAIL reset_outputs phase=%0d got rd=%b wr=%b mbe=%h addr=%h wdata=%h cnt=%h required all zero",
                         k, mem_read_o, mem_write_o, mem_mbe_o, mem_addr_o, mem_wdata_o, conflict_cnt_o);
            end
            if (k == 0) begin
                repeat (2) @(posedge clk_i);
                #1 rst_ni = 1;
                @(negedge clk_i);
            end
        end
    endtask

    task automatic test_instr_alone();
        int ir0 = n_ir;
        mem_lat = 0;
        @(posedge clk_i); #1;
        fork
            instr_req(32'h60);
            begin
                @(negedge clk_i);
                tests++;
                if (mem_read_o !== 1'b0) begin
                    fails++; $display("FAIL instr_grant_latency got mem_read=%b in request cycle required 0", mem_read_o);
                end
                @(negedge clk_i);
                tests++;
                if ({mem_read_o, mem_addr_o, instr_resp_o, instr_rdata_o} !== {1'b1, 32'h60, 1'b1, 32'h13}) begin
                    fails++;
                    $display("FAIL instr_strobe got rd=%b addr=%h resp=%b rdata=%h required 1 00000060 1 00000013",
                             mem_read_o, mem_addr_o, instr_resp_o, instr_rdata_o);
                end
            end
        join
        @(negedge clk_i);
        tests++;
        if ({mem_read_o, instr_resp_o, conflict_cnt_o, n_ir - ir0} !== {1'b0, 1'b0, {CW{1'b0}}, 32'd1}) begin
            fails++;
            $display("FAIL instr_after got rd=%b resp=%b cnt=%0d resps=%0d required 0 0 0 1",
                     mem_read_o, instr_resp_o, conflict_cnt_o, n_ir - ir0);
        end
    endtask

    task automatic test_store();
        int ir0 = n_ir, dr0 = n_dr;
        mem_lat = 3;
        @(posedge clk_i); #1;
        fork
            data_req(1'b1, 32'h100, 32'hDEADBEEF, 4'b0011);
            begin
                @(negedge clk_i);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk_i);
                    tests++;
                    if ({mem_write_o, mem_read_o, mem_addr_o, mem_wdata_o, mem_mbe_o, data_resp_o, instr_resp_o} !==
                        {1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'b0011, k == 3, 1'b0}) begin
                        fails++;
                        $display("FAIL store_hold cycle=%0d got wr=%b rd=%b addr=%h wdata=%h mbe=%b dresp=%b iresp=%b required 1 0 100 deadbeef 0011 %0d 0",
                                 k, mem_write_o, mem_read_o, mem_addr_o, mem_wdata_o, mem_mbe_o, data_resp_o, instr_resp_o, k == 3);
                    end
                end
            end
        join
        tests++;
        if (n_dr - dr0 != 1 || n_ir != ir0) begin
            fails++; $display("FAIL store_resp_count got data=%0d instr=%0d required 1 0", n_dr - dr0, n_ir - ir0);
        end
    endtask

    task automatic test_contention();
        logic [CW-1:0] c0;
        logic          instr_first;
        mem_lat = 0;
        @(posedge clk_i); #1;
        instr_req(32'h7C);
        for (int r = 0; r < 2; r++) begin
            c0 = conflict_cnt_o;
            fork
                instr_req(32'h80 + 32'(r * 8));
                data_req(1'b0, 32'h90 + 32'(r * 8), 32'h0, 4'hF);
            join
`ifdef ARB_ROUND_ROBIN_EN
            instr_first = r == 1;
`else
            instr_first = 1'b0;
`endif
            tests++;
            if ((instr_first ? last_dr - last_ir : last_ir - last_dr) != 2) begin
                fails++;
                $display("FAIL contention_order round=%0d got instr_cyc=%0d data_cyc=%0d required %s first, other 2 cycles later",
                         r, last_ir, last_dr, instr_first ? "instr" : "data");
            end
            tests++;
            if (conflict_cnt_o !== c0 + CW'(1)) begin
                fails++; $display("FAIL contention_count round=%0d got %0d required %0d", r, conflict_cnt_o, c0 + CW'(1));
            end
            if (r == 0) data_req(1'b0, 32'hA0, 32'h0, 4'hF);
        end
    endtask

    task automatic test_addr_change();
        mem_lat = 4;
        @(posedge clk_i); #1;
        fork
            data_req(1'b0, 32'h200, 32'h0, 4'hF);
            begin
                @(posedge clk_i); #1 data_addr_i = 32'h204;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk_i);
                    tests++;
                    if ({mem_read_o, mem_addr_o} !== {1'b1, 32'h200}) begin
                        fails++;
                        $display("FAIL addr_hold cycle=%0d got rd=%b addr=%h required 1 00000200", k, mem_read_o, mem_addr_o);
                    end
                end
            end
        join
    endtask

    task automatic test_saturation();
        logic [CW-1:0] c0 = conflict_cnt_o;
        mem_lat = 0;
        for (int i = 0; i < (1 << CW) + 5; i++) begin
            fork
                instr_req(32'h400 + 32'(i * 4));
                data_req(i[0], 32'h800 + 32'(i * 4), 32'(i), 4'(i));
            join
            if (i == 9) begin
                tests++;
                if (conflict_cnt_o !== c0 + CW'(10)) begin
                    fails++; $display("FAIL sat_progress got %0d required %0d", conflict_cnt_o, c0 + CW'(10));
                end
            end
        end
        tests++;
        if (conflict_cnt_o !== {CW{1'b1}}) begin
            fails++; $display("FAIL sat_hold got %h required %h", conflict_cnt_o, {CW{1'b1}});
        end
    endtask

    task automatic test_reset_mid();
        int dr0 = n_dr, ir0 = n_ir;
        mem_lat = 50;
        @(posedge clk_i); #1;
        data_write_i = 1; data_addr_i = 32'h300; data_wdata_i = 32'h12345678; data_mbe_i = 4'hF;
        @(posedge clk_i); #2;
        tests++;
        if (mem_write_o !== 1'b1) begin
            fails++; $display("FAIL mid_pre_write got %b required 1", mem_write_o);
        end
        #1 rst_ni = 0;
        #1;
        tests++;
        if ({mem_write_o, mem_read_o, mem_addr_o, conflict_cnt_o} !== '0) begin
            fails++;
            $display("FAIL mid_async_reset got wr=%b rd=%b addr=%h cnt=%0d required all zero",
                     mem_write_o, mem_read_o, mem_addr_o, conflict_cnt_o);
        end
        data_write_i = 0;
        @(posedge clk_i); #1 rst_ni = 1;
        @(negedge clk_i); stray = 1;
        #1;
        tests++;
        if ({instr_resp_o, data_resp_o, instr_rdata_o, data_rdata_o} !== '0) begin
            fails++;
            $display("FAIL stray_resp got iresp=%b dresp=%b irdata=%h drdata=%h required all zero",
                     instr_resp_o, data_resp_o, instr_rdata_o, data_rdata_o);
        end
        @(posedge clk_i); #1 stray = 0;
        @(negedge clk_i);
        tests++;
        if ({mem_read_o, mem_write_o, n_dr - dr0, n_ir - ir0} !== {2'b00, 32'd0, 32'd0}) begin
            fails++;
            $display("FAIL post_reset_idle got rd=%b wr=%b dresps=%0d iresps=%0d required 0 0 0 0",
                     mem_read_o, mem_write_o, n_dr - dr0, n_ir - ir0);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_instr_alone();
        test_store();
        test_contention();
        test_addr_change();
        test_saturation();
        test_reset_mid();
        tests++;
        if (iq.size() != 0 || dq.size() != 0) begin
            fails++; $display("FAIL scoreboard_drain got instr=%0d data=%0d pending required 0 0", iq.size(), dq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
